// File: rtl/regdump_pkg.sv
// Shared types and defaults for the register-file dump controller.
package regdump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } regdump_state_t;

    localparam logic [3:0] REGDUMP_CSUM_IDX = 4'd8;
    localparam int         REGDUMP_NUM_REGS = 8;
    localparam int         REGDUMP_DATA_W   = 16;

endpackage

// File: rtl/regdump_out_stage.sv
// Output holding stage: one word offered on a valid/ready stream,
// held stable from load until accepted.
module regdump_out_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [3:0]        idx_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [3:0]        idx_o,
    output logic              last_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        idx_q;
    logic              last_q;

    // A load in the same cycle as an accept replaces the accepted word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            idx_q   <= idx_i;
            last_q  <= last_i;
        end else if (accept_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Sequential register-file dumper onto a valid/ready stream.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump_ctrl
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = REGDUMP_NUM_REGS,
    parameter int DATA_W   = REGDUMP_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [2:0]        Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [3:0]        Out_Idx,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    regdump_state_t    state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              busy_q, done_q;
    logic              load, hs;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        ld_idx;
    logic              ld_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    assign hs = Out_Valid & Out_Ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ld_data = Rd_Data;
        ld_idx  = idx_q;
        ld_last = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = READ;
                end
            end
            READ: begin
                load    = 1'b1;
                state_d = SEND;
`ifdef REGDUMP_CHECKSUM_EN
                csum_d  = csum_q ^ Rd_Data;
`else
                ld_last = (idx_q == LAST_IDX);
`endif
            end
            SEND: begin
                if (hs) begin
                    if (Out_Last) begin
                        state_d = FIN;
                    end
`ifdef REGDUMP_CHECKSUM_EN
                    // Checksum word skips READ and is offered straight away.
                    else if (idx_q == LAST_IDX) begin
                        load    = 1'b1;
                        ld_data = csum_q;
                        ld_idx  = REGDUMP_CSUM_IDX;
                        ld_last = 1'b1;
                    end
`endif
                    else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = READ;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIN);
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end
`endif

    regdump_out_stage #(.DATA_W(DATA_W)) u_out (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .load_i   (load),
        .accept_i (hs),
        .data_i   (ld_data),
        .idx_i    (ld_idx),
        .last_i   (ld_last),
        .valid_o  (Out_Valid),
        .data_o   (Out_Data),
        .idx_o    (Out_Idx),
        .last_o   (Out_Last)
    );

    assign Rd_Addr = (state_q == READ) ? idx_q[2:0] : 3'd0;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl with a behavioural register file.
module tb_regfile_dump_ctrl;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Rd_Addr;
    logic [15:0] Rd_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Out_Data;
    logic [3:0]  Out_Idx;
    logic        Out_Last;
    logic        Busy;
    logic        Done;

    logic [15:0] rf [8];
    assign Rd_Data = rf[Rd_Addr];

    always #5 Clk = ~Clk;

    regfile_dump_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Rd_Addr   (Rd_Addr),
        .Rd_Data   (Rd_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Out_Idx   (Out_Idx),
        .Out_Last  (Out_Last),
        .Busy      (Busy),
        .Done      (Done)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] gd [16];
    logic [3:0]  gi [16];
    logic        gl [16];
    int          gc [16];
    int          n, done_cnt, done_cyc, stab_err, timed_out;
    logic        valid_at1, busy_at1;

    int          nwr;
    int          wr_cyc [4];
    int          wr_reg [4];
    logic [15:0] wr_val [4];

    // Runs one dump; records accepted words, Done pulses and stability faults.
    task automatic collect(input int mode, input int abort_cyc, input int spam);
        logic        held;
        logic [15:0] hd;
        logic [3:0]  hi;
        logic        hl;
        int          stall;
        n = 0; done_cnt = 0; done_cyc = -1; stab_err = 0;
        timed_out = 1; held = 1'b0; stall = 0;
        hd = '0; hi = '0; hl = 1'b0;
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge Clk);
            Start = (spam != 0 && c >= 2 && c <= 14) ?
                    1'($urandom_range(0, 1)) : 1'b0;
            for (int w = 0; w < nwr; w++)
                if (wr_cyc[w] == c) rf[wr_reg[w]] = wr_val[w];
            if (c == abort_cyc) begin
                timed_out = 0;
                return;
            end
            if (c == 1) begin
                valid_at1 = Out_Valid;
                busy_at1  = Busy;
            end
            case (mode)
                0: Out_Ready = 1'b1;
                1: Out_Ready = 1'($urandom_range(0, 1));
                default: begin
                    if (Out_Valid && Out_Idx == 4'd3 && stall < 5) begin
                        Out_Ready = 1'b0;
                        stall++;
                    end else begin
                        Out_Ready = 1'b1;
                    end
                end
            endcase
            if (held && !Out_Valid) stab_err++;
            if (held && Out_Valid &&
                {hd, hi, hl} != {Out_Data, Out_Idx, Out_Last}) stab_err++;
            held = Out_Valid && !Out_Ready;
            hd = Out_Data; hi = Out_Idx; hl = Out_Last;
            if (Out_Valid && Out_Ready && n < 16) begin
                gd[n] = Out_Data; gi[n] = Out_Idx;
                gl[n] = Out_Last; gc[n] = c;
                n++;
            end
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 2) begin
                timed_out = 0;
                break;
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; Out_Ready = 1'b0; nwr = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        tests++;
        if ({Out_Valid, Busy, Done, Out_Last} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags got %b want 0000",
                     {Out_Valid, Busy, Done, Out_Last});
        end
        tests++;
        if ({Out_Data, Out_Idx, Rd_Addr} !== 23'd0) begin
            fails++;
            $display("FAIL reset_data got %h/%h/%h want 0",
                     Out_Data, Out_Idx, Rd_Addr);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_basic;
        logic [15:0] x;
        for (int k = 0; k < 8; k++) rf[k] = 16'(k * 16'h1111);
        nwr = 0;
        Out_Ready = 1'b1;
        collect(0, 0, 0);
        x = '0;
        for (int k = 0; k < 8; k++) x ^= rf[k];
        tests++;
        if (timed_out != 0 || n != NW) begin
            fails++;
            $display("FAIL basic_count got %0d to=%0d want %0d", n, timed_out, NW);
        end
        tests++;
        if (valid_at1 !== 1'b0 || busy_at1 !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency got v=%b b=%b want v=0 b=1",
                     valid_at1, busy_at1);
        end
        for (int k = 0; k < n && k < NW; k++) begin
            tests++;
            if (k < 8) begin
                if (gd[k] !== rf[k] || gi[k] !== 4'(k) ||
                    gl[k] !== (NW == 8 && k == 7) || gc[k] != 2 + 2 * k) begin
                    fails++;
                    $display("FAIL basic_word%0d got %h i%0d l%b c%0d want %h i%0d c%0d",
                             k, gd[k], gi[k], gl[k], gc[k], rf[k], k, 2 + 2 * k);
                end
            end else begin
                if (gd[k] !== x || gi[k] !== 4'd8 || gl[k] !== 1'b1 || gc[k] != 17) begin
                    fails++;
                    $display("FAIL basic_csum got %h i%0d l%b c%0d want %h i8 l1 c17",
                             gd[k], gi[k], gl[k], gc[k], x);
                end
            end
        end
        tests++;
        if (done_cnt != 1 || done_cyc != 1 + 2 * NW - (NW - 8)) begin
            fails++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d want 1/%0d",
                     done_cnt, done_cyc, 1 + 2 * NW - (NW - 8));
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_busy got %b want 0", Busy);
        end
    endtask

    task automatic test_stall;
        for (int k = 0; k < 8; k++) rf[k] = 16'(k * 16'h1111);
        nwr = 0;
        collect(2, 0, 0);
        tests++;
        if (timed_out != 0 || n != NW || stab_err != 0) begin
            fails++;
            $display("FAIL stall_stream got n=%0d to=%0d stab=%0d want %0d/0/0",
                     n, timed_out, stab_err, NW);
        end
        tests++;
        if (gd[3] !== 16'h3333 || gi[3] !== 4'd3 || gc[3] != 13) begin
            fails++;
            $display("FAIL stall_word3 got %h i%0d c%0d want 3333 i3 c13",
                     gd[3], gi[3], gc[3]);
        end
        tests++;
        if (gi[4] !== 4'd4 || gc[4] != 15) begin
            fails++;
            $display("FAIL stall_word4 got i%0d c%0d want i4 c15", gi[4], gc[4]);
        end
    endtask

    task automatic test_rf_writes;
        logic [15:0] base [8];
        logic [15:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            rf[k] = 16'(k * 16'h1111);
            base[k] = rf[k];
        end
        nwr = 2;
        wr_cyc[0] = 6; wr_reg[0] = 6; wr_val[0] = 16'hBEEF;
        wr_cyc[1] = 6; wr_reg[1] = 1; wr_val[1] = 16'hDEAD;
        collect(0, 0, 0);
        nwr = 0;
        tests++;
        if (timed_out != 0 || n != NW) begin
            fails++;
            $display("FAIL wr_count got %0d want %0d", n, NW);
        end
        // A register is seen with every write landing no later than its read cycle.
        for (int k = 0; k < 8 && k < n; k++) begin
            exp_v = base[k];
            for (int w = 0; w < 2; w++)
                if (wr_reg[w] == k && wr_cyc[w] <= 1 + 2 * k) exp_v = wr_val[w];
            tests++;
            if (gd[k] !== exp_v) begin
                fails++;
                $display("FAIL wr_word%0d got %h want %h", k, gd[k], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 8; k++) rf[k] = 16'(k * 16'h1111);
        nwr = 0;
        collect(0, 12, 0);
        tests++;
        if (Out_Valid !== 1'b1 || Out_Idx !== 4'd5) begin
            fails++;
            $display("FAIL rstmid_pre got v=%b i%0d want v=1 i5", Out_Valid, Out_Idx);
        end
        #2 Reset = 1'b1;
        #1;
        tests++;
        if ({Out_Valid, Busy, Done, Out_Last} !== 4'b0 || Out_Data !== 16'h0 ||
            Out_Idx !== 4'h0 || Rd_Addr !== 3'h0) begin
            fails++;
            $display("FAIL rstmid_clear got v%b b%b d%h i%0d want 0",
                     Out_Valid, Busy, Out_Data, Out_Idx);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        collect(0, 0, 0);
        tests++;
        if (timed_out != 0 || n != NW || gi[0] !== 4'd0 || gd[0] !== rf[0]) begin
            fails++;
            $display("FAIL rstmid_restart got n=%0d i%0d d%h want %0d i0 d%h",
                     n, gi[0], gd[0], NW, rf[0]);
        end
    endtask

    task automatic test_checksum_and_spam;
        logic [15:0] x;
        for (int k = 0; k < 8; k++) rf[k] = 16'(1 << k);
        nwr = 0;
        collect(0, 0, 1);
        x = '0;
        for (int k = 0; k < 8; k++) x ^= rf[k];
        tests++;
        if (timed_out != 0 || n != NW || done_cnt != 1) begin
            fails++;
            $display("FAIL spam_count got n=%0d done=%0d want %0d/1", n, done_cnt, NW);
        end
        for (int k = 0; k < n && k < 8; k++) begin
            tests++;
            if (gi[k] !== 4'(k) || gd[k] !== rf[k]) begin
                fails++;
                $display("FAIL spam_word%0d got i%0d %h want i%0d %h",
                         k, gi[k], gd[k], k, rf[k]);
            end
        end
`ifdef REGDUMP_CHECKSUM_EN
        tests++;
        if (gi[8] !== 4'd8 || gd[8] !== 16'h00FF || gl[8] !== 1'b1 || x !== 16'h00FF) begin
            fails++;
            $display("FAIL csum_word got i%0d %h l%b want i8 00ff l1", gi[8], gd[8], gl[8]);
        end
`else
        tests++;
        if (gl[7] !== 1'b1 || gi[n-1] === 4'd8) begin
            fails++;
            $display("FAIL nocsum_last got l%b last_idx %0d want l1 idx7", gl[7], gi[n-1]);
        end
`endif
        repeat (3) @(negedge Clk);
        tests++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0) begin
            fails++;
            $display("FAIL spam_no_restart got b%b v%b want 0 0", Busy, Out_Valid);
        end
    endtask

    task automatic test_random;
        logic [15:0] x;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
            nwr = 0;
            collect(1, 0, it & 1);
            x = '0;
            for (int k = 0; k < 8; k++) x ^= rf[k];
            tests++;
            if (timed_out != 0 || n != NW || stab_err != 0 || done_cnt != 1) begin
                fails++;
                $display("FAIL rand%0d_stream got n=%0d to=%0d stab=%0d done=%0d",
                         it, n, timed_out, stab_err, done_cnt);
            end
            for (int k = 0; k < n && k < NW; k++) begin
                tests++;
                if (gd[k] !== (k < 8 ? rf[k] : x) || gi[k] !== 4'(k) ||
                    gl[k] !== (k == NW - 1)) begin
                    fails++;
                    $display("FAIL rand%0d_word%0d got %h i%0d l%b want %h",
                             it, k, gd[k], gi[k], gl[k], (k < 8 ? rf[k] : x));
                end
            end
            repeat (2) @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_rf_writes();
        test_reset_mid();
        test_checksum_and_spam();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
